// File: rtl/etapa2_multi_if.sv
// etapa2_multi_if: bus bundle between the stage-2 engine and its upstream/BRAM side.
//   master modport: upstream (drives data_done, mode and the BRAM read data)
//   slave  modport: etapa2_multi engine
// Signals: data_done/mode (start + run mode), BRAM_input (BRAM doutb),
//          busy/done status, enable_read/read_addr (BRAM enb/addrb),
//          s2_Out result array, sum_out (only with ETAPA2_SUM_EN).
interface etapa2_multi_if #(
  parameter int DEPTH = 144,
  parameter int DW    = 17,
  parameter int AW    = 8,
  parameter int OW    = 2*DW+1,
  parameter int SW    = OW+$clog2(DEPTH)
);
  logic                 data_done;
  logic                 mode;
  logic [DW-1:0]        BRAM_input;
  logic                 busy;
  logic                 done;
  logic                 enable_read;
  logic [AW-1:0]        read_addr;
  logic signed [OW-1:0] s2_Out [DEPTH];
`ifdef ETAPA2_SUM_EN
  logic signed [SW-1:0] sum_out;
`endif

  modport master (
    output data_done, mode, BRAM_input,
    input  busy, done, enable_read, read_addr, s2_Out
`ifdef ETAPA2_SUM_EN
    , input sum_out
`endif
  );

  modport slave (
    input  data_done, mode, BRAM_input,
    output busy, done, enable_read, read_addr, s2_Out
`ifdef ETAPA2_SUM_EN
    , output sum_out
`endif
  );
endinterface

// File: rtl/etapa2_multi.sv
// etapa2_multi: stage-2 engine. On data_done it streams DEPTH samples from a
// synchronous-read BRAM (latency READ_LAT), computes x[k]*x[k] (mode 0) or
// x[k]*x[k-1] (mode 1) and stores each signed product in s2_Out[k].
// Ports: clk, reset (synchronous, active-low), bus (etapa2_multi_if.slave).
// Optional feature: define ETAPA2_SUM_EN to add the sum_out running sum.
module etapa2_multi #(
  parameter int DEPTH    = 144,
  parameter int DW       = 17,
  parameter int AW       = 8,
  parameter int READ_LAT = 1,
  parameter int OW       = 2*DW+1
) (
  input logic           clk,
  input logic           reset,
  etapa2_multi_if.slave bus
);
  localparam int unsigned RL = READ_LAT;
`ifdef ETAPA2_SUM_EN
  localparam int SW = OW+$clog2(DEPTH);
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 mode_q, mode_d;
  logic signed [DW-1:0] lag_q, lag_d;
  // Read-issue tracking: a sample arrives RL cycles after its address.
  logic [RL-1:0]        vld_q, vld_d;
  logic [AW-1:0]        idx_q [RL];
  logic [AW-1:0]        idx_d [RL];
  logic signed [OW-1:0] s2_q [DEPTH];
  logic signed [OW-1:0] s2_d [DEPTH];
`ifdef ETAPA2_SUM_EN
  logic signed [SW-1:0] sum_q, sum_d;
`endif

  logic                   start, wr, last_wr;
  logic [AW-1:0]          wr_idx;
  logic signed [DW-1:0]   x, op;
  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0]   prod_ext;

  always_comb begin
    start    = (state_q == IDLE) && bus.data_done;
    wr       = vld_q[RL-1];
    wr_idx   = idx_q[RL-1];
    last_wr  = wr && (wr_idx == AW'(DEPTH-1));
    x        = bus.BRAM_input;
    op       = mode_q ? lag_q : x;
    prod     = (2*DW)'(x) * (2*DW)'(op);
    prod_ext = OW'(prod);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    lag_d   = lag_q;
    s2_d    = s2_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    vld_d[0] = en_q;
    idx_d[0] = addr_q;
    for (int unsigned i = 1; i < RL; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    if (wr) begin
      s2_d[wr_idx] = prod_ext;
      lag_d        = x;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        addr_d  = '0;
        mode_d  = bus.mode;
        lag_d   = '0;
      end
      READ: if (addr_q == AW'(DEPTH-1)) state_d = DRAIN;
            else                         addr_d  = addr_q + 1'b1;
      // Leave as soon as the final product is being written, so done
      // coincides with the last entry becoming visible.
      DRAIN: if (last_wr) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == READ) || (state_d == DRAIN);
    en_d   = (state_d == READ);
    done_d = (state_d == DONE);
  end

`ifdef ETAPA2_SUM_EN
  always_comb begin
    sum_d = sum_q;
    if (start)   sum_d = '0;
    else if (wr) sum_d = sum_q + SW'(prod_ext);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      lag_q   <= '0;
      vld_q   <= '0;
      idx_q   <= '{default: '0};
      s2_q    <= '{default: '0};
`ifdef ETAPA2_SUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      lag_q   <= lag_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      s2_q    <= s2_d;
`ifdef ETAPA2_SUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.enable_read = en_q;
  assign bus.read_addr   = addr_q;
  assign bus.s2_Out      = s2_q;
`ifdef ETAPA2_SUM_EN
  assign bus.sum_out     = sum_q;
`endif
endmodule
